// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier (MUL/MULS/UMULL/SMULL) with its own
// IDLE/RUN/FIX/DONE controller; operates on magnitudes and fixes the sign at the end.
module mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic             Long,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       Flags
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
    if (neg) begin
      apply_sign = ~v + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      apply_sign = v;
    end
  endfunction

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic [PW-1:0]   mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [PW-1:0]   acc_r;
  logic            neg_r;
  logic            long_r;
  logic            busy_r;
  logic            done_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_hi_r;
  logic [1:0]      flags_r;
  logic            accept_s;
  logic            last_iter_s;
  logic [PW-1:0]   final_s;

  assign accept_s    = Start && ((state_r == IDLE) || (state_r == DONE));
  assign last_iter_s = (cnt_r == LAST_CNT) ||
                       ((EARLY_EXIT != 0) && (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}));
  assign final_s     = apply_sign(acc_r, neg_r);

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_iter_s) state_s = FIX;
        else             state_s = RUN;
      end
      FIX:     state_s = DONE;
      DONE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration, sign fix-up and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= {CW{1'b0}};
      mcand_r     <= {PW{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {PW{1'b0}};
      neg_r       <= 1'b0;
      long_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      flags_r     <= 2'b00;
    end else begin
      busy_r <= (state_s == RUN) || (state_s == FIX);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            cnt_r    <= {CW{1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, magnitude(SrcA, Signed)};
            mplier_r <= magnitude(SrcB, Signed);
            acc_r    <= {PW{1'b0}};
            neg_r    <= (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) & Signed;
            long_r   <= Long;
          end
        end
        RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_ONE;
        end
        FIX: begin
          result_r    <= final_s[WIDTH-1:0];
          result_hi_r <= final_s[PW-1:WIDTH];
          if (long_r) begin
            flags_r <= {final_s[PW-1], (final_s == {PW{1'b0}})};
          end else begin
            flags_r <= {final_s[WIDTH-1], (final_s[WIDTH-1:0] == {WIDTH{1'b0}})};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Result   = result_r;
  assign ResultHi = result_hi_r;
  assign Flags    = flags_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer: one instance per EARLY_EXIT setting,
// hand-computed products, latencies and flags.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_drv = 1'b0;
  logic        ee_sel = 1'b0;
  logic        sgn = 1'b0;
  logic        lng = 1'b0;
  logic [31:0] srca = 32'd0;
  logic [31:0] srcb = 32'd0;

  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, hi0, res1, hi1;
  logic [1:0]  fl0, fl1;
  logic        start0, start1;
  logic        busy_m, done_m;
  logic [31:0] res_m, hi_m;
  logic [1:0]  fl_m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  assign start0 = start_drv & ~ee_sel;
  assign start1 = start_drv & ee_sel;
  assign busy_m = ee_sel ? busy1 : busy0;
  assign done_m = ee_sel ? done1 : done0;
  assign res_m  = ee_sel ? res1 : res0;
  assign hi_m   = ee_sel ? hi1 : hi0;
  assign fl_m   = ee_sel ? fl1 : fl0;

  mul_sequencer #(.WIDTH(32), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .reset(reset), .Start(start0), .Signed(sgn), .Long(lng),
    .SrcA(srca), .SrcB(srcb), .Busy(busy0), .Done(done0),
    .Result(res0), .ResultHi(hi0), .Flags(fl0)
  );

  mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1)) dut_early (
    .clk(clk), .reset(reset), .Start(start1), .Signed(sgn), .Long(lng),
    .SrcA(srca), .SrcB(srcb), .Busy(busy1), .Done(done1),
    .Result(res1), .ResultHi(hi1), .Flags(fl1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called near a falling edge; the operation is accepted on the next rising edge.
  task automatic start_op(input logic ee, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic l);
    ee_sel    = ee;
    srca      = a;
    srcb      = b;
    sgn       = s;
    lng       = l;
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    t0        = cyc;
    start_drv = 1'b0;
  endtask

  // Returns at the falling edge inside the Done cycle.
  task automatic wait_done(input string tag, input int exp_lat, input bit chk_busy);
    bit got = 1'b0;
    int busyn = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_m) begin
        got = 1'b1;
        break;
      end
      if (busy_m) busyn++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
    check({tag, "_busy_low_at_done"}, 64'(busy_m), 64'd0);
    if (chk_busy) check({tag, "_busy_cycles"}, 64'(busyn), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic ee, input logic [31:0] a,
                        input logic [31:0] b, input logic s, input logic l,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic [1:0] exp_fl, input int exp_lat);
    start_op(ee, a, b, s, l);
    check({tag, "_busy_after_accept"}, 64'(busy_m), 64'd1);
    wait_done(tag, exp_lat, 1'b1);
    check({tag, "_result"}, 64'(res_m), 64'(exp_lo));
    check({tag, "_resulthi"}, 64'(hi_m), 64'(exp_hi));
    check({tag, "_flags"}, 64'(fl_m), 64'(exp_fl));
  endtask

  initial begin
    bit saw_done;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_result", 64'(res1), 64'd0);
    check("rst_resulthi", 64'(hi1), 64'd0);
    check("rst_flags", 64'(fl0), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full-length iteration count: WIDTH iterations plus the FIX cycle.
    run_op("u7x6", 1'b0, 32'd7, 32'd6, 1'b0, 1'b0, 32'h0000002A, 32'h0, 2'b00, 33);
    @(negedge clk);
    run_op("sneg1x1", 1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 33);
    @(negedge clk);

    run_op("sm3x5", 1'b1, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10, 4);
    @(negedge clk);
    run_op("uF1x5", 1'b1, 32'hFFFFFFF1, 32'd5, 1'b0, 1'b1, 32'hFFFFFFB5, 32'h00000004, 2'b00, 4);
    @(negedge clk);
    run_op("smin_long", 1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h0, 32'h40000000, 2'b00, 33);
    @(negedge clk);
    run_op("smin_short", 1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h0, 32'h40000000, 2'b01, 33);
    @(negedge clk);
    run_op("b_zero", 1'b1, 32'h00001234, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 2);
    @(negedge clk);
    run_op("b_ones", 1'b1, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 2'b00, 33);

    // Back-to-back: the second Start is presented in the DONE cycle of the first.
    run_op("b2b_first", 1'b1, 32'd3, 32'd5, 1'b0, 1'b0, 32'd15, 32'h0, 2'b00, 4);
    run_op("b2b_second", 1'b1, 32'hFFFFFFFE, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 2'b10, 3);
    @(negedge clk);

    // Start while busy must not disturb the operation in flight.
    start_op(1'b0, 32'd100, 32'd3, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    srca = 32'd9;
    srcb = 32'd9;
    sgn  = 1'b1;
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    wait_done("ignore_start", 33, 1'b0);
    check("ignore_start_result", 64'(res_m), 64'h12C);
    check("ignore_start_flags", 64'(fl_m), 64'd0);
    @(negedge clk);
    check("ignore_start_no_rerun", 64'(busy_m), 64'd0);

    // Reset mid-operation.
    start_op(1'b0, 32'd7, 32'd6, 1'b0, 1'b0);
    while (cyc < t0 + 10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_done", 64'(done0), 64'd0);
    check("midrst_result", 64'(res0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done0 || busy0) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);
    run_op("after_rst", 1'b0, 32'd7, 32'd6, 1'b0, 1'b0, 32'h0000002A, 32'h0, 2'b00, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
